// File: rtl/consumatore_media_pkg.sv
// Shared definitions for the consumatore_media handshake consumer:
// FSM encoding, default group size and sample width.
package consumatore_media_pkg;

    localparam int SAMPLE_W      = 8;
    localparam int LOG_N_DEFAULT = 2;

    typedef enum logic {
        ATTESA   = 1'b0,
        CONFERMA = 1'b1
    } stato_t;

endpackage

// File: rtl/accumulatore_media.sv
// Accumulates captured samples in groups of 2^LOG_N and publishes the floor
// of each group's mean together with a one-cycle update strobe.
module accumulatore_media
    import consumatore_media_pkg::*;
#(
    parameter int LOG_N = LOG_N_DEFAULT
) (
    input  logic                clock,
    input  logic                reset_,
    input  logic                cattura,
    input  logic [SAMPLE_W-1:0] x,
    output logic [SAMPLE_W-1:0] media,
    output logic                nuovo
);

    localparam int SUM_W = SAMPLE_W + LOG_N;
    localparam logic [LOG_N-1:0] ULTIMO = {LOG_N{1'b1}};
    localparam logic [LOG_N-1:0] UNO    = LOG_N'(32'd1);

    logic [SUM_W-1:0]    somma_r;
    logic [LOG_N-1:0]    conta_r;
    logic [SAMPLE_W-1:0] media_r;
    logic                nuovo_r;
    logic [SUM_W-1:0]    somma_next_s;

    // Sum including the sample being captured; wide enough that it never wraps.
    always_comb begin
        somma_next_s = somma_r + {{LOG_N{1'b0}}, x};
    end

    // Sum/count registers, published mean and update strobe.
    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            somma_r <= '0;
            conta_r <= '0;
            media_r <= '0;
            nuovo_r <= 1'b0;
        end else if (cattura) begin
            if (conta_r == ULTIMO) begin
                media_r <= somma_next_s[SUM_W-1:LOG_N];
                somma_r <= '0;
                conta_r <= '0;
                nuovo_r <= 1'b1;
            end else begin
                somma_r <= somma_next_s;
                conta_r <= conta_r + UNO;
                nuovo_r <= 1'b0;
            end
        end else begin
            nuovo_r <= 1'b0;
        end
    end

    assign media = media_r;
    assign nuovo = nuovo_r;

endmodule

// File: rtl/consumatore_media.sv
// Acknowledging side of the dav_/rfd byte handshake: one capture per dav_ low
// phase, feeding the group-mean accumulator.
module consumatore_media
    import consumatore_media_pkg::*;
#(
    parameter int LOG_N = LOG_N_DEFAULT
) (
    input  logic                clock,
    input  logic                reset_,
    input  logic                dav_,
    input  logic [SAMPLE_W-1:0] x,
    output logic                rfd,
    output logic [SAMPLE_W-1:0] media,
    output logic                nuovo
);

    stato_t stato_r;
    stato_t stato_next_s;
    logic   rfd_r;
    logic   cattura_s;

    // Next-state logic; a capture happens only on leaving ATTESA.
    always_comb begin
        stato_next_s = stato_r;
        cattura_s    = 1'b0;
        case (stato_r)
            ATTESA: begin
                if (!dav_) begin
                    stato_next_s = CONFERMA;
                    cattura_s    = 1'b1;
                end else begin
                    stato_next_s = ATTESA;
                end
            end
            CONFERMA: begin
                if (dav_) begin
                    stato_next_s = ATTESA;
                end else begin
                    stato_next_s = CONFERMA;
                end
            end
            default: begin
                stato_next_s = ATTESA;
            end
        endcase
    end

    // State register and registered acknowledge.
    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            stato_r <= ATTESA;
            rfd_r   <= 1'b0;
        end else begin
            stato_r <= stato_next_s;
            rfd_r   <= (stato_next_s == CONFERMA);
        end
    end

    assign rfd = rfd_r;

    accumulatore_media #(
        .LOG_N (LOG_N)
    ) u_accumulatore (
        .clock   (clock),
        .reset_  (reset_),
        .cattura (cattura_s),
        .x       (x),
        .media   (media),
        .nuovo   (nuovo)
    );

endmodule
